// File: rtl/kgp_ctrl_pkg.sv
// Shared definitions for the front-panel run/step sequencer: state encoding and
// default timing parameters.
package kgp_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int STEP_LEN_DEF        = 4;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_STEP   = ST_STEP,
    S_HALTED = ST_HALTED
  } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton front end: 2-flop synchronizer, stable-count debounce and a
// one-cycle pulse on each accepted press.
module btn_conditioner
  import kgp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 5
) (
  input  logic clkf,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clkf) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      // Any agreement with the accepted level restarts the stability count.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_db;
  assign pulse = r_db & ~r_db_q;

endmodule

// File: rtl/run_controller.sv
// Run/step sequencer: gates the clock-divider start enable from the debounced
// run and step buttons and the CPU halt level.
//
// state  | meaning
// IDLE   | CPU clock frozen, waiting for run or step
// RUN    | free running until halt or a run press (pause)
// STEP   | start held high for STEP_LEN cycles, then back to IDLE
// HALTED | CPU halted; only reset leaves this state
module run_controller
  import kgp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int STEP_LEN        = STEP_LEN_DEF,
  parameter int CNT_W           = 5
) (
  input  logic       clkf,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       halt,
  output logic       start,
  output logic       running,
  output logic       halted,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] LP_STEP_LAST = CNT_W'(STEP_LEN - 1);

  logic             w_run_pulse;
  logic             w_step_pulse;
  logic             w_run_level;
  logic             w_step_level;
  logic             w_unused_levels;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] w_step_cnt_nxt;
  logic             r_halt_q;
  logic             r_start;
  logic             r_running;
  logic             r_halted;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_run (
    .clkf (clkf),
    .rst  (rst),
    .raw  (btn_run),
    .level(w_run_level),
    .pulse(w_run_pulse)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_step (
    .clkf (clkf),
    .rst  (rst),
    .raw  (btn_step),
    .level(w_step_level),
    .pulse(w_step_pulse)
  );

  // Debounced levels are only needed by the panel LEDs elsewhere.
  assign w_unused_levels = w_run_level ^ w_step_level;

  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_halt_q) begin
          w_state_nxt = S_HALTED;
        end else if (w_run_pulse) begin
          w_state_nxt = S_RUN;
        end else if (w_step_pulse) begin
          w_state_nxt    = S_STEP;
          w_step_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        if (r_halt_q) begin
          w_state_nxt = S_HALTED;
        end else if (w_run_pulse) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        if (r_halt_q) begin
          w_state_nxt = S_HALTED;
        end else if (r_step_cnt == LP_STEP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step_cnt_nxt = r_step_cnt + CNT_W'(1);
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clkf) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_step_cnt <= '0;
      r_halt_q   <= 1'b0;
      r_start    <= 1'b0;
      r_running  <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_halt_q   <= halt;
      r_start    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
      r_running  <= (w_state_nxt == S_RUN);
      r_halted   <= (w_state_nxt == S_HALTED);
    end
  end

  assign start   = r_start;
  assign running = r_running;
  assign halted  = r_halted;
  assign state   = r_state;

endmodule
